// File: rtl/l2_line_merge_unit_if.sv
// Request, way-data, pmem fill and merged-output signals of the L2 line merge unit.
// The unit sits on the slave side. The cache datapath, pmem and the consumer sit on the master side.
interface l2_line_merge_unit_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 128
);
    localparam int NUM_CHUNKS = LINE_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = $clog2(NUM_CHUNKS);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic                     req_hit;
    logic [IDX_W-1:0]         req_chunk_idx;
    logic [CHUNK_WIDTH-1:0]   req_wdata;
    logic [CHUNK_WIDTH/8-1:0] req_wmask;
    logic [LINE_WIDTH-1:0]    way_data;

    logic                     pmem_read;
    logic                     pmem_resp;
    logic [LINE_WIDTH-1:0]    pmem_rdata;

    logic                     out_valid;
    logic                     out_ready;
    logic [LINE_WIDTH-1:0]    out_line;
    logic [CHUNK_WIDTH-1:0]   out_chunk;
    logic                     out_dirty;
    logic                     out_from_fill;

    modport master (
        output req_valid, req_write, req_hit, req_chunk_idx, req_wdata, req_wmask, way_data,
        output pmem_resp, pmem_rdata, out_ready,
        input  req_ready, pmem_read, out_valid, out_line, out_chunk, out_dirty, out_from_fill
    );

    modport slave (
        input  req_valid, req_write, req_hit, req_chunk_idx, req_wdata, req_wmask, way_data,
        input  pmem_resp, pmem_rdata, out_ready,
        output req_ready, pmem_read, out_valid, out_line, out_chunk, out_dirty, out_from_fill
    );
endinterface

// File: rtl/l2_line_merge_unit.sv
// Merges a byte-masked write chunk into a cache line. The base line is the way line on a hit,
// or a line fetched from pmem on a miss. The result is held in registers until the consumer takes it.
module l2_line_merge_unit #(
    parameter int LINE_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_line_merge_unit_if.slave  bus
);
    localparam int NUM_CHUNKS  = LINE_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W       = $clog2(NUM_CHUNKS);
    localparam int CHUNK_BYTES = CHUNK_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_OUT
    } state_t;

    state_t                 state_q;
    logic                   write_q;
    logic                   hit_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CHUNK_WIDTH-1:0] wdata_q;
    logic [CHUNK_BYTES-1:0] wmask_q;

    logic                   req_ready_q;
    logic                   pmem_read_q;
    logic                   out_valid_q;
    logic [LINE_WIDTH-1:0]  out_line_q;
    logic [CHUNK_WIDTH-1:0] out_chunk_q;
    logic                   out_dirty_q;
    logic                   out_from_fill_q;

    logic [LINE_WIDTH-1:0]  base_line;
    logic                   m_write;
    logic [IDX_W-1:0]       m_idx;
    logic [CHUNK_WIDTH-1:0] m_wdata;
    logic [CHUNK_BYTES-1:0] m_wmask;
    int                     chunk_base;
    logic [LINE_WIDTH-1:0]  line_d;
    logic [CHUNK_WIDTH-1:0] chunk_d;
    logic                   dirty_d;

    // One merge datapath serves both cases. On a hit it uses the live request and way_data.
    // In FILL it uses the captured request and the pmem line.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        base_line = bus.way_data;
        m_write   = bus.req_write;
        m_idx     = bus.req_chunk_idx;
        m_wdata   = bus.req_wdata;
        m_wmask   = bus.req_wmask;
        if (state_q == S_FILL) begin
            base_line = bus.pmem_rdata;
            m_write   = write_q;
            m_idx     = idx_q;
            m_wdata   = wdata_q;
            m_wmask   = wmask_q;
        end

        chunk_base = int'(m_idx) * CHUNK_WIDTH;
        line_d     = base_line;
        for (int b = 0; b < CHUNK_BYTES; b++) begin
            if (m_write && m_wmask[b]) begin
                line_d[chunk_base + b*8 +: 8] = m_wdata[b*8 +: 8];
            end
        end
        chunk_d = line_d[chunk_base +: CHUNK_WIDTH];
        dirty_d = m_write & (|m_wmask);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            state_q         <= S_IDLE;
            write_q         <= 1'b0;
            hit_q           <= 1'b0;
            idx_q           <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            req_ready_q     <= 1'b1;
            pmem_read_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_line_q      <= '0;
            out_chunk_q     <= '0;
            out_dirty_q     <= 1'b0;
            out_from_fill_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        write_q     <= bus.req_write;
                        hit_q       <= bus.req_hit;
                        idx_q       <= bus.req_chunk_idx;
                        wdata_q     <= bus.req_wdata;
                        wmask_q     <= bus.req_wmask;
                        req_ready_q <= 1'b0;
                        if (bus.req_hit) begin
                            out_line_q      <= line_d;
                            out_chunk_q     <= chunk_d;
                            out_dirty_q     <= dirty_d;
                            out_from_fill_q <= 1'b0;
                            out_valid_q     <= 1'b1;
                            state_q         <= S_OUT;
                        end else begin
                            pmem_read_q <= 1'b1;
                            state_q     <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.pmem_resp) begin
                        out_line_q      <= line_d;
                        out_chunk_q     <= chunk_d;
                        out_dirty_q     <= dirty_d;
                        out_from_fill_q <= ~hit_q;
                        out_valid_q     <= 1'b1;
                        pmem_read_q     <= 1'b0;
                        state_q         <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.pmem_read     = pmem_read_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_line      = out_line_q;
    assign bus.out_chunk     = out_chunk_q;
    assign bus.out_dirty     = out_dirty_q;
    assign bus.out_from_fill = out_from_fill_q;
endmodule

// File: tb/tb_l2_line_merge_unit.sv
// Self-checking bench for l2_line_merge_unit. It uses a byte-array reference model.
// It runs a 256/128 instance through scenarios and random traffic, and a 512/64 instance for the parameter sweep.
module tb_l2_line_merge_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    l2_line_merge_unit_if #(.LINE_WIDTH(256), .CHUNK_WIDTH(128)) bus ();
    l2_line_merge_unit_if #(.LINE_WIDTH(512), .CHUNK_WIDTH(64))  bus_w ();

    l2_line_merge_unit #(.LINE_WIDTH(256), .CHUNK_WIDTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    l2_line_merge_unit #(.LINE_WIDTH(512), .CHUNK_WIDTH(64)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // The reference model treats the line as an array of bytes. The chunk holds bytes idx*16 .. idx*16+15.
    function automatic logic [255:0] model_line(input logic [255:0] base, input logic w, input int idx,
                                                input logic [127:0] wd, input logic [15:0] wm);
        logic [7:0]   bytes [32];
        logic [255:0] r;
        for (int n = 0; n < 32; n++) bytes[n] = base[n*8 +: 8];
        if (w) begin
            for (int b = 0; b < 16; b++) begin
                if (wm[b]) bytes[idx*16 + b] = wd[b*8 +: 8];
            end
        end
        for (int n = 0; n < 32; n++) r[n*8 +: 8] = bytes[n];
        return r;
    endfunction

    function automatic logic [127:0] model_chunk(input logic [255:0] line, input int idx);
        logic [255:0] sh;
        sh = line >> (idx * 128);
        return sh[127:0];
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents one request for a single cycle starting at a negedge.
    // It returns at the next negedge, so the accept edge N has already passed.
    task automatic issue(input logic w, input logic h, input logic idx, input logic [127:0] wd,
                         input logic [15:0] wm, input logic [255:0] way);
        bus.req_valid     = 1'b1;
        bus.req_write     = w;
        bus.req_hit       = h;
        bus.req_chunk_idx = idx;
        bus.req_wdata     = wd;
        bus.req_wmask     = wm;
        bus.way_data      = way;
        @(negedge clk);
        bus.req_valid     = 1'b0;
        bus.req_wdata     = ~wd;
        bus.req_wmask     = ~wm;
        bus.way_data      = ~way;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pmem_resp = 1'b1;
        bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.req_valid = 1'b0;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b want 0", bus.pmem_read); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_line !== 256'd0) begin errors++; $display("FAIL reset_out_line: got %h want 0", bus.out_line); end
        checks++; if (bus.out_chunk !== 128'd0) begin errors++; $display("FAIL reset_out_chunk: got %h want 0", bus.out_chunk); end
        checks++; if (bus.out_dirty !== 1'b0) begin errors++; $display("FAIL reset_out_dirty: got %b want 0", bus.out_dirty); end
        checks++; if (bus.out_from_fill !== 1'b0) begin errors++; $display("FAIL reset_out_from_fill: got %b want 0", bus.out_from_fill); end
    endtask

    task automatic test_hit_partial();
        logic [255:0] exp_line;
        exp_line = 256'hAAAAAAAA << 128;
        issue(1'b1, 1'b1, 1'b1, {16{8'hAA}}, 16'h000F, 256'd0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hit_valid_n1: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_line !== exp_line) begin errors++; $display("FAIL hit_line: got %h want %h", bus.out_line, exp_line); end
        checks++; if (bus.out_chunk !== exp_line[255:128]) begin errors++; $display("FAIL hit_chunk: got %h want %h", bus.out_chunk, exp_line[255:128]); end
        checks++; if (bus.out_dirty !== 1'b1) begin errors++; $display("FAIL hit_dirty: got %b want 1", bus.out_dirty); end
        checks++; if (bus.out_from_fill !== 1'b0) begin errors++; $display("FAIL hit_from_fill: got %b want 0", bus.out_from_fill); end
        checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL hit_pmem_read: got %b want 0", bus.pmem_read); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL hit_release: valid %b ready %b want 0 1", bus.out_valid, bus.req_ready);
        end
    endtask

    task automatic test_miss_fill();
        logic [255:0] exp_line;
        int           read_cycles;
        exp_line    = {{16{8'hFF}}, {16{8'h11}}};
        read_cycles = 0;
        issue(1'b1, 1'b0, 1'b0, {16{8'h11}}, 16'hFFFF, 256'd0);
        for (int i = 0; i < 5; i++) begin
            if (bus.pmem_read === 1'b1) read_cycles++;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL miss_early_valid: cycle %0d got %b want 0", i, bus.out_valid); end
            bus.pmem_resp  = (i == 4);
            bus.pmem_rdata = (i == 4) ? {32{8'hFF}} : rand256();
            @(negedge clk);
        end
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = rand256();
        if (bus.pmem_read === 1'b1) read_cycles++;
        checks++; if (read_cycles != 5) begin errors++; $display("FAIL miss_read_cycles: got %0d want 5", read_cycles); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL miss_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_line !== exp_line) begin errors++; $display("FAIL miss_line: got %h want %h", bus.out_line, exp_line); end
        checks++; if (bus.out_from_fill !== 1'b1) begin errors++; $display("FAIL miss_from_fill: got %b want 1", bus.out_from_fill); end
        checks++; if (bus.out_dirty !== 1'b1) begin errors++; $display("FAIL miss_dirty: got %b want 1", bus.out_dirty); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_read_miss();
        logic [255:0] pattern;
        pattern = rand256();
        issue(1'b0, 1'b0, 1'b1, 128'h0123, 16'hFFFF, 256'd0);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = pattern;
        checks++; if (bus.out_valid !== 1'b0 || bus.pmem_read !== 1'b1) begin
            errors++; $display("FAIL rdmiss_n1: valid %b pmem_read %b want 0 1", bus.out_valid, bus.pmem_read);
        end
        @(negedge clk);
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = ~pattern;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rdmiss_valid_n2: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_line !== pattern) begin errors++; $display("FAIL rdmiss_line: got %h want %h", bus.out_line, pattern); end
        checks++; if (bus.out_chunk !== pattern[255:128]) begin errors++; $display("FAIL rdmiss_chunk: got %h want %h", bus.out_chunk, pattern[255:128]); end
        checks++; if (bus.out_dirty !== 1'b0) begin errors++; $display("FAIL rdmiss_dirty: got %b want 0", bus.out_dirty); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [255:0] way;
        logic [127:0] wd;
        logic [15:0]  wm;
        logic [255:0] exp_line;
        way      = rand256();
        wd       = {$urandom(), $urandom(), $urandom(), $urandom()};
        wm       = 16'($urandom());
        exp_line = model_line(way, 1'b1, 0, wd, wm);
        issue(1'b1, 1'b1, 1'b0, wd, wm, way);
        for (int i = 0; i < 4; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_hit    = 1'b1;
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rand256();
            checks++; if (bus.out_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: valid %b ready %b want 1 0", i, bus.out_valid, bus.req_ready);
            end
            checks++; if (bus.out_line !== exp_line || bus.out_chunk !== exp_line[127:0]) begin
                errors++; $display("FAIL bp_stable_%0d: got %h want %h", i, bus.out_line, exp_line);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: ready %b valid %b want 1 0", bus.req_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] way;
        logic [127:0] wd;
        way = rand256();
        wd  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.out_ready = 1'b1;
        issue(1'b1, 1'b1, 1'b1, wd, 16'hFFFF, way);
        checks++; if (bus.out_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first: valid %b ready %b want 1 0", bus.out_valid, bus.req_ready);
        end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
        issue(1'b0, 1'b1, 1'b0, wd, 16'hFFFF, way);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_line !== way || bus.out_dirty !== 1'b0) begin
            errors++; $display("FAIL b2b_second: valid %b line %h dirty %b want 1 %h 0", bus.out_valid, bus.out_line, bus.out_dirty, way);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        issue(1'b1, 1'b0, 1'b1, 128'hDEAD, 16'h00FF, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.pmem_read !== 1'b0 || bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rstfill_after: pmem_read %b ready %b valid %b want 0 1 0", bus.pmem_read, bus.req_ready, bus.out_valid);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rand256();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.out_line !== 256'd0) begin
                errors++; $display("FAIL rstfill_stray_resp_%0d: valid %b ready %b line %h want 0 1 0", i, bus.out_valid, bus.req_ready, bus.out_line);
            end
        end
        bus.pmem_resp = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic         w;
            logic         h;
            int           idx;
            logic [127:0] wd;
            logic [15:0]  wm;
            logic [255:0] way;
            logic [255:0] fill;
            logic [255:0] exp_line;
            int           d;
            int           fills;
            int           cyc;
            w    = 1'($urandom());
            h    = 1'($urandom());
            idx  = int'($urandom_range(0, 1));
            wd   = {$urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       wm = 16'h0000;
                1:       wm = 16'hFFFF;
                default: wm = 16'($urandom());
            endcase
            way  = rand256();
            fill = rand256();
            d    = int'($urandom_range(0, 4));
            exp_line = model_line(h ? way : fill, w, idx, wd, wm);
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready_%0d: got %b want 1", t, bus.req_ready); end
            issue(w, h, 1'(idx), wd, wm, way);
            fills = 0;
            cyc   = 0;
            while (bus.out_valid !== 1'b1 && cyc < 20) begin
                if (bus.pmem_read === 1'b1) fills++;
                bus.pmem_resp  = (fills == d + 1);
                bus.pmem_rdata = (fills == d + 1) ? fill : rand256();
                @(negedge clk);
                cyc++;
            end
            bus.pmem_resp = 1'b0;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rnd_timeout_%0d: out_valid got %b want 1", t, bus.out_valid); end
            checks++; if (fills != (h ? 0 : d + 1)) begin errors++; $display("FAIL rnd_fill_cycles_%0d: got %0d want %0d", t, fills, h ? 0 : d + 1); end
            checks++; if (bus.out_line !== exp_line) begin errors++; $display("FAIL rnd_line_%0d: got %h want %h", t, bus.out_line, exp_line); end
            checks++; if (bus.out_chunk !== model_chunk(exp_line, idx)) begin
                errors++; $display("FAIL rnd_chunk_%0d: got %h want %h", t, bus.out_chunk, model_chunk(exp_line, idx));
            end
            checks++; if (bus.out_dirty !== (w && wm != 16'd0) || bus.out_from_fill !== !h) begin
                errors++; $display("FAIL rnd_flags_%0d: dirty %b fill %b want %b %b", t, bus.out_dirty, bus.out_from_fill, (w && wm != 16'd0), !h);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_param_sweep();
        logic [511:0] way;
        logic [63:0]  wd;
        way = {rand256(), rand256()};
        wd  = {$urandom(), $urandom()};
        for (int pass = 0; pass < 2; pass++) begin
            bus_w.req_valid     = 1'b1;
            bus_w.req_write     = 1'b1;
            bus_w.req_hit       = 1'b1;
            bus_w.req_chunk_idx = 3'd7;
            bus_w.req_wdata     = wd;
            bus_w.req_wmask     = (pass == 0) ? 8'h00 : 8'hFF;
            bus_w.way_data      = way;
            @(negedge clk);
            bus_w.req_valid = 1'b0;
            bus_w.way_data  = ~way;
            if (pass == 0) begin
                checks++; if (bus_w.out_line !== way || bus_w.out_dirty !== 1'b0) begin
                    errors++; $display("FAIL sweep_zero_mask: line %h dirty %b want %h 0", bus_w.out_line, bus_w.out_dirty, way);
                end
            end else begin
                checks++; if (bus_w.out_line !== {wd, way[447:0]}) begin
                    errors++; $display("FAIL sweep_full_mask: got %h want %h", bus_w.out_line, {wd, way[447:0]});
                end
                checks++; if (bus_w.out_chunk !== wd || bus_w.out_dirty !== 1'b1) begin
                    errors++; $display("FAIL sweep_chunk: chunk %h dirty %b want %h 1", bus_w.out_chunk, bus_w.out_dirty, wd);
                end
            end
            bus_w.out_ready = 1'b1;
            @(negedge clk);
            bus_w.out_ready = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_hit = 1'b0; bus.req_chunk_idx = '0;
        bus.req_wdata = '0; bus.req_wmask = '0; bus.way_data = '0;
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0; bus.out_ready = 1'b0;
        bus_w.req_valid = 1'b0; bus_w.req_write = 1'b0; bus_w.req_hit = 1'b0; bus_w.req_chunk_idx = '0;
        bus_w.req_wdata = '0; bus_w.req_wmask = '0; bus_w.way_data = '0;
        bus_w.pmem_resp = 1'b0; bus_w.pmem_rdata = '0; bus_w.out_ready = 1'b0;
        @(negedge clk);

        test_reset();
        test_hit_partial();
        test_miss_fill();
        test_read_miss();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_fill();
        test_random();
        test_param_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
